// File: rtl/imem_load_controller.sv
// imem_load_controller
// Sequencer/arbiter for the single address/write port of the instruction memory.
// A host loader streams write beats into the memory. The fetch stage issues
// single-word reads, but only after a complete program has been loaded.
// Loading has absolute priority over fetching.
//
// Ports:
//   CLk, reset          clock; asynchronous active-high reset
//   load_start/count    request a load session of load_count words
//   load_valid/data     write beat from the host
//   load_ready          controller accepts a beat this cycle (combinational)
//   fetch_req/addr      read request from the fetch stage
//   fetch_grant         read accepted this cycle (combinational)
//   fetch_valid/fault   registered read result flags, one cycle after grant
//   fetch_instr         passthrough of mem_instruction
//   mem_address/write/data   memory port (combinational)
//   mem_instruction     registered read data from memory
//   loaded, prog_length resident-program status
module imem_load_controller #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 32
) (
   input  logic                  CLk,
   input  logic                  reset,
   input  logic                  load_start,
   input  logic [ADDR_WIDTH:0]   load_count,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_ready,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic                  fetch_grant,
   output logic                  fetch_valid,
   output logic                  fetch_fault,
   output logic [DATA_WIDTH-1:0] fetch_instr,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_write,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic [DATA_WIDTH-1:0] mem_instruction,
   output logic                  loaded,
   output logic [ADDR_WIDTH:0]   prog_length
);

   localparam int unsigned CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t                state;
   logic [CW-1:0]         count;
   logic [ADDR_WIDTH-1:0] ptr;

   logic                  beat_c;
   logic                  last_beat_c;
   logic                  start_ok_c;
   logic [CW-1:0]         clamped_count_c;

   // Beat acceptance and session-start qualification
   assign beat_c          = load_valid && load_ready;
   assign last_beat_c     = beat_c && ({1'b0, ptr} == (count - CW'(1)));
   assign start_ok_c      = load_start && (load_count != '0);
   assign clamped_count_c = (load_count > DEPTH_C) ? DEPTH_C : load_count;

   assign fetch_instr = mem_instruction;

   // Port arbitration: a load beat owns the port, otherwise a granted fetch
   always_comb begin
      load_ready  = 1'b0;
      fetch_grant = 1'b0;
      mem_address = '0;
      mem_write   = 1'b0;
      mem_data    = '0;
      load_ready  = (state == LOAD);
      // A load_start in RUN pre-empts a same-cycle fetch request
      fetch_grant = (state == RUN) && fetch_req && !load_start;
      if (beat_c) begin
         mem_address = ptr;
         mem_write   = 1'b1;
         mem_data    = load_data;
      end else if (fetch_grant) begin
         mem_address = fetch_addr;
      end
   end

   // Controller state and registered status outputs
   always_ff @(posedge CLk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         ptr         <= '0;
         loaded      <= 1'b0;
         prog_length <= '0;
         fetch_valid <= 1'b0;
         fetch_fault <= 1'b0;
      end else begin
         // A grant issued just before entering LOAD still yields its result
         fetch_valid <= fetch_grant;
         fetch_fault <= fetch_grant && (CW'(fetch_addr) >= prog_length);
         case (state)
            IDLE, RUN: begin
               if (start_ok_c) begin
                  state       <= LOAD;
                  count       <= clamped_count_c;
                  ptr         <= '0;
                  loaded      <= 1'b0;
                  prog_length <= '0;
               end
            end
            LOAD: begin
               if (beat_c) begin
                  ptr <= ptr + ADDR_WIDTH'(1);
                  if (last_beat_c) begin
                     state       <= RUN;
                     loaded      <= 1'b1;
                     prog_length <= count;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_load_controller.sv
// Directed self-checking bench for imem_load_controller with a small
// registered-read memory model attached to the memory port.
module tb_imem_load_controller;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic          CLk;
   logic          reset;
   logic          load_start;
   logic [AW:0]   load_count;
   logic          load_valid;
   logic [DW-1:0] load_data;
   logic          load_ready;
   logic          fetch_req;
   logic [AW-1:0] fetch_addr;
   logic          fetch_grant;
   logic          fetch_valid;
   logic          fetch_fault;
   logic [DW-1:0] fetch_instr;
   logic [AW-1:0] mem_address;
   logic          mem_write;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] mem_instruction;
   logic          loaded;
   logic [AW:0]   prog_length;

   int n_assert = 0;
   int n_fail   = 0;

   imem_load_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(32)) dut (
      .CLk(CLk), .reset(reset),
      .load_start(load_start), .load_count(load_count),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_grant(fetch_grant),
      .fetch_valid(fetch_valid), .fetch_fault(fetch_fault), .fetch_instr(fetch_instr),
      .mem_address(mem_address), .mem_write(mem_write), .mem_data(mem_data),
      .mem_instruction(mem_instruction),
      .loaded(loaded), .prog_length(prog_length)
   );

   initial CLk = 1'b0;
   always #5 CLk = ~CLk;

   // Memory: latches address/write on the edge, read data valid next cycle
   logic [DW-1:0] mem_model [32];
   always @(posedge CLk) begin
      if (mem_write) mem_model[mem_address] <= mem_data;
      mem_instruction <= mem_model[mem_address];
   end

   task automatic tick();
      @(posedge CLk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; load_start = 1'b0; load_count = '0; load_valid = 1'b0;
      load_data = '0; fetch_req = 1'b0; fetch_addr = '0;
      #1;
      chk("rst_load_ready", 64'(load_ready), 64'd0);
      chk("rst_loaded", 64'(loaded), 64'd0);
      chk("rst_prog_length", 64'(prog_length), 64'd0);
      chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
      chk("rst_fetch_fault", 64'(fetch_fault), 64'd0);
      chk("rst_mem_write", 64'(mem_write), 64'd0);
      tick(); tick();
      reset = 1'b0;

      // Fetch in IDLE is never granted
      fetch_req = 1'b1; fetch_addr = 5'd0;
      #1 chk("idle_grant", 64'(fetch_grant), 64'd0);
      tick();
      fetch_req = 1'b0;
      chk("idle_fetch_valid", 64'(fetch_valid), 64'd0);

      // Load four words
      load_start = 1'b1; load_count = 6'd4;
      #1 chk("idle_load_ready", 64'(load_ready), 64'd0);
      tick();
      load_start = 1'b0;
      chk("load_ready", 64'(load_ready), 64'd1);
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1; load_data = 32'(32'h11 * (i + 1));
         #1;
         chk("beat_write", 64'(mem_write), 64'd1);
         chk("beat_addr", 64'(mem_address), 64'(i));
         chk("beat_data", 64'(mem_data), 64'(32'h11 * (i + 1)));
         tick();
      end
      load_valid = 1'b0;
      chk("loaded_4", 64'(loaded), 64'd1);
      chk("prog_len_4", 64'(prog_length), 64'd4);
      chk("run_load_ready", 64'(load_ready), 64'd0);

      // Back-to-back fetches 2,0,3
      fetch_req = 1'b1; fetch_addr = 5'd2;
      #1;
      chk("grant_a2", 64'(fetch_grant), 64'd1);
      chk("grant_addr", 64'(mem_address), 64'd2);
      chk("grant_nowrite", 64'(mem_write), 64'd0);
      tick();
      fetch_addr = 5'd0;
      chk("f2_valid", 64'(fetch_valid), 64'd1);
      chk("f2_instr", 64'(fetch_instr), 64'h33);
      chk("f2_fault", 64'(fetch_fault), 64'd0);
      tick();
      fetch_addr = 5'd3;
      chk("f0_valid", 64'(fetch_valid), 64'd1);
      chk("f0_instr", 64'(fetch_instr), 64'h11);
      tick();
      fetch_addr = 5'd4;
      chk("f3_valid", 64'(fetch_valid), 64'd1);
      chk("f3_instr", 64'(fetch_instr), 64'h44);
      chk("f3_fault", 64'(fetch_fault), 64'd0);
      tick();
      fetch_addr = 5'd7;
      chk("f4_valid", 64'(fetch_valid), 64'd1);
      chk("f4_fault", 64'(fetch_fault), 64'd1);
      tick();
      fetch_req = 1'b0;
      chk("f7_fault", 64'(fetch_fault), 64'd1);
      tick();
      chk("idle_after_valid", 64'(fetch_valid), 64'd0);

      // load_start in RUN beats a simultaneous fetch
      load_start = 1'b1; load_count = 6'd2; fetch_req = 1'b1; fetch_addr = 5'd1;
      #1;
      chk("pre_grant", 64'(fetch_grant), 64'd0);
      chk("pre_addr", 64'(mem_address), 64'd0);
      tick();
      load_start = 1'b0; fetch_req = 1'b0;
      chk("pre_valid", 64'(fetch_valid), 64'd0);
      chk("reload_loaded", 64'(loaded), 64'd0);
      chk("reload_len", 64'(prog_length), 64'd0);
      chk("reload_ready", 64'(load_ready), 64'd1);
      #1 chk("gap1_write", 64'(mem_write), 64'd0);
      tick();
      load_valid = 1'b1; load_data = 32'hA0;
      #1 chk("b0_addr", 64'(mem_address), 64'd0);
      tick();
      // Gap with stale data and an ignored load_start
      load_valid = 1'b0; load_data = 32'hFF; load_start = 1'b1; load_count = 6'd5;
      #1;
      chk("gap2_write", 64'(mem_write), 64'd0);
      chk("gap2_data", 64'(mem_data), 64'd0);
      tick();
      load_start = 1'b0;
      chk("gap2_loaded", 64'(loaded), 64'd0);
      load_valid = 1'b1; load_data = 32'hA1;
      #1 chk("b1_addr", 64'(mem_address), 64'd1);
      tick();
      load_valid = 1'b0;
      chk("loaded_2", 64'(loaded), 64'd1);
      chk("prog_len_2", 64'(prog_length), 64'd2);
      fetch_req = 1'b1; fetch_addr = 5'd1;
      tick();
      fetch_addr = 5'd2;
      chk("r1_instr", 64'(fetch_instr), 64'hA1);
      chk("r1_fault", 64'(fetch_fault), 64'd0);
      tick();
      fetch_req = 1'b0;
      chk("r2_fault", 64'(fetch_fault), 64'd1);
      chk("r2_instr", 64'(fetch_instr), 64'h33);

      // Oversized count clamps to 32 words
      load_start = 1'b1; load_count = 6'd40;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 32; i++) begin
         load_valid = 1'b1; load_data = 32'h1000 + 32'(i);
         #1 chk("clamp_addr", 64'(mem_address), 64'(i));
         tick();
      end
      load_valid = 1'b0;
      chk("loaded_32", 64'(loaded), 64'd1);
      chk("prog_len_32", 64'(prog_length), 64'd32);
      fetch_req = 1'b1; fetch_addr = 5'd31;
      tick();
      fetch_req = 1'b0;
      chk("r31_instr", 64'(fetch_instr), 64'h101F);
      chk("r31_fault", 64'(fetch_fault), 64'd0);

      // Zero-length start is ignored
      load_start = 1'b1; load_count = 6'd0;
      tick();
      load_start = 1'b0;
      chk("zero_ready", 64'(load_ready), 64'd0);
      chk("zero_loaded", 64'(loaded), 64'd1);
      chk("zero_len", 64'(prog_length), 64'd32);

      // Reset drops a pending fetch result
      fetch_req = 1'b1; fetch_addr = 5'd0;
      tick();
      fetch_req = 1'b0;
      chk("pend_valid", 64'(fetch_valid), 64'd1);
      reset = 1'b1;
      #1;
      chk("rst_drop_valid", 64'(fetch_valid), 64'd0);
      chk("rst_drop_loaded", 64'(loaded), 64'd0);
      tick();
      reset = 1'b0;

      // Reset mid-load
      load_start = 1'b1; load_count = 6'd4;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1; load_data = 32'h55;
      tick();
      load_data = 32'h66;
      tick();
      load_valid = 1'b0;
      chk("mid_ready", 64'(load_ready), 64'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_ready", 64'(load_ready), 64'd0);
      chk("mid_rst_loaded", 64'(loaded), 64'd0);
      chk("mid_rst_len", 64'(prog_length), 64'd0);
      tick();
      reset = 1'b0;

      // Fresh one-word load and fetch
      load_start = 1'b1; load_count = 6'd1;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1; load_data = 32'hABCD;
      tick();
      load_valid = 1'b0;
      chk("loaded_1", 64'(loaded), 64'd1);
      chk("prog_len_1", 64'(prog_length), 64'd1);
      fetch_req = 1'b1; fetch_addr = 5'd0;
      tick();
      fetch_addr = 5'd1;
      chk("abcd_instr", 64'(fetch_instr), 64'hABCD);
      chk("abcd_fault", 64'(fetch_fault), 64'd0);
      tick();
      fetch_req = 1'b0;
      chk("a1_fault", 64'(fetch_fault), 64'd1);

      // Grant in the cycle before a load still returns its result
      fetch_req = 1'b1; fetch_addr = 5'd0;
      tick();
      fetch_req = 1'b0; load_start = 1'b1; load_count = 6'd1;
      chk("late_valid", 64'(fetch_valid), 64'd1);
      chk("late_instr", 64'(fetch_instr), 64'hABCD);
      tick();
      load_start = 1'b0;
      chk("late_load", 64'(load_ready), 64'd1);
      chk("late_drop", 64'(fetch_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_load_controller.md
# imem_load_controller

Sequencer and arbiter for the 32-word instruction memory. Owns the memory's single address/write port and shares it between a host program loader (streaming write beats) and the fetch stage (single-word reads). Loading has absolute priority; fetches are granted only once a complete program is resident. Sits between the host/test interface, the fetch stage and the instruction memory.

## Interface
Parameters:
- ADDR_WIDTH, 5, memory word-address width
- DATA_WIDTH, 32, instruction width
- DEPTH, 32, number of memory words (2**ADDR_WIDTH)

Ports:
- CLk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all controller state
- load_start  in  1  request a load session of load_count words
- load_count  in  ADDR_WIDTH+1  words to load, sampled with load_start
- load_valid  in  1  load_data holds a valid beat
- load_data  in  DATA_WIDTH  instruction word to write
- load_ready  out  1  controller accepts a beat this cycle
- fetch_req  in  1  fetch stage requests a read
- fetch_addr  in  ADDR_WIDTH  word address to read
- fetch_grant  out  1  request accepted this cycle (combinational)
- fetch_valid  out  1  fetch_instr valid this cycle
- fetch_fault  out  1  with fetch_valid: address beyond loaded program
- fetch_instr  out  DATA_WIDTH  read data, passthrough of mem_instruction
- mem_address  out  ADDR_WIDTH  memory address
- mem_write  out  1  memory write enable
- mem_data  out  DATA_WIDTH  memory write data
- mem_instruction  in  DATA_WIDTH  memory registered read data
- loaded  out  1  complete program resident
- prog_length  out  ADDR_WIDTH+1  words in resident program

## Operation
- States: IDLE, LOAD, RUN. Reset → IDLE; loaded=0, prog_length=0, load pointer=0, fetch_valid=0, fetch_fault=0.
- IDLE/RUN + load_start with load_count≠0 → LOAD; count latched, clamped to DEPTH if larger; pointer=0; loaded=0, prog_length=0. load_count=0: start ignored.
- LOAD: load_ready=1. Beat accepted when load_valid&&load_ready: mem_write=1, mem_address=pointer, mem_data=load_data; pointer increments. Beat on pointer==count−1 → RUN next cycle, loaded=1, prog_length=count. load_start during LOAD ignored. No beat → state holds indefinitely.
- RUN: fetch_grant=fetch_req && !load_start. On grant: mem_address=fetch_addr, mem_write=0. load_start in RUN wins over a simultaneous fetch_req (no grant; LOAD next cycle).
- IDLE: fetch_grant=0, load_ready=0.
- When no write or grant: mem_address=0, mem_write=0, mem_data=0.
- fetch_fault set when granted fetch_addr ≥ prog_length; fetch_instr still passed through.
- Memory contents are not cleared by reset or by a new load; only loaded/prog_length gate use.

## Timing
- Memory latches address/write on the same edge the controller drives them; read data appears the following cycle.
- Fetch latency 1: grant in cycle k → fetch_valid=1 (registered) and fetch_instr valid in cycle k+1. Back-to-back grants give one result per cycle.
- A grant issued the cycle before a transition to LOAD still yields its fetch_valid in the next cycle.
- Load throughput: one beat per cycle; last beat in cycle k → loaded=1 and RUN from cycle k+1, earliest grant in cycle k+1.
- Reset asserted mid-LOAD or mid-fetch: outputs return to reset values immediately; pending fetch_valid dropped.

## Test plan
- Reset, load_start with load_count=4, beats 0x11,0x22,0x33,0x44 on consecutive cycles → mem_write at addresses 0–3, loaded=1 and prog_length=4 the cycle after the last beat.
- After the above, fetch_req with addresses 2,0,3 on consecutive cycles → fetch_valid on the following three cycles, fetch_instr=0x33,0x11,0x44, fetch_fault=0.
- fetch_addr=7 with prog_length=4 → fetch_valid=1, fetch_fault=1 one cycle later; fetch_req in IDLE → no grant, no fetch_valid.
- In RUN, load_start (count=2) together with fetch_req → fetch_grant=0, LOAD next cycle, loaded=0; load_valid gaps stall the pointer with no spurious writes.
- load_count=40 → clamped, 32 beats accepted, prog_length=32; load_count=0 → stays in current state.
- reset asserted after 2 of 4 beats → IDLE, loaded=0, load_ready=0 immediately; fresh load of 1 word (0xABCD) then fetch of address 0 → fetch_instr=0xABCD.
